reg_dump: RTL and testbench

Register-file readback engine for the mini MIPS datapath. On a start pulse it walks a contiguous range of register indices through a register-file read port and streams each value, tagged with its index, over a valid/ready interface. Debug and test logic use it to drain architectural state without hierarchical peeking. It is purely a reader: it never drives the register file's write port, and the core's writes continue while a dump runs.

---
 rtl/reg_dump.sv | 151 +++++++++++++++
 tb/tb_reg_dump.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump.sv
// reg_dump
//
// Register-file readback engine. A start pulse names an inclusive range of
// register indices [first, last]. The engine steps through the range one
// index at a time. For each index it drives the register file's
// combinational read port, captures the value, and offers the
// (index, value) pair on a valid/ready stream. It only reads the register
// file and never touches the write port, so core writes carry on while a
// dump is running.
//
// Parameters
//   ADDR_W     register index width
//   DATA_W     register data width
//
// Ports
//   clk        single clock, rising-edge
//   reset      synchronous, active-high
//   start      dump request, only honoured while idle
//   first      first index of the dump, sampled with an accepted start
//   last       last index of the dump (inclusive), sampled with start
//   rd_addr    read-select to the register file (0 whenever not reading)
//   rd_data    combinational read data for rd_addr
//   out_valid  out_data/out_index hold a word for the consumer
//   out_ready  consumer accepts the word
//   out_data   captured register value
//   out_index  register index that out_data came from
//   busy       high in every state except IDLE
//   done       one-cycle pulse after the final word is accepted
//   err        one-cycle pulse after a start with first > last is rejected

module reg_dump #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first,
    input  logic [ADDR_W-1:0] last,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q,   idx_d;
    logic [ADDR_W-1:0] limit_q, limit_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [ADDR_W-1:0] oidx_q,  oidx_d;
    logic              err_q,   err_d;
    logic              handshake;

    // A handshake can only happen in SEND. out_ready is ignored in every
    // other state.
    assign handshake = (state_q == SEND) && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            limit_q <= '0;
            data_q  <= '0;
            oidx_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            limit_q <= limit_d;
            data_q  <= data_d;
            oidx_q  <= oidx_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        limit_d = limit_q;
        data_d  = data_q;
        oidx_d  = oidx_q;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (first > last) begin
                        err_d = 1'b1;
                    end else begin
                        idx_d   = first;
                        limit_d = last;
                        state_d = READ;
                    end
                end
            end

            // The value captured here is what the register file holds just
            // before this edge. A write that lands on the same edge is not
            // visible in this word.
            READ: begin
                data_d  = rd_data;
                oidx_d  = idx_q;
                state_d = SEND;
            end

            // The counter stops at the limit instead of incrementing. This
            // lets last = 2**ADDR_W-1 finish without the counter wrapping.
            SEND: begin
                if (handshake) begin
                    if (idx_q == limit_q) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = READ;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The read select stays at 0 outside READ so the register file sees a
    // quiet, predictable address while the engine is idle or waiting.
    assign rd_addr   = (state_q == READ) ? idx_q : '0;
    assign out_valid = (state_q == SEND);
    assign out_data  = data_q;
    assign out_index = oidx_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_reg_dump.sv
module tb_reg_dump;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] first;
    logic [ADDR_W-1:0] last;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_index;
    logic              busy;
    logic              done;
    logic              err;

    logic [DATA_W-1:0] regs    [32];
    logic [DATA_W-1:0] expWord [32];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Behavioural register file: combinational read, written by the bench.
    assign rd_data = regs[rd_addr];

    reg_dump #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .first    (first),
        .last     (last),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_index(out_index),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_busy"},      busy,      0);
        checkOutput({tag, "_out_valid"}, out_valid, 0);
        checkOutput({tag, "_done"},      done,      0);
        checkOutput({tag, "_err"},       err,       0);
        checkOutput({tag, "_out_data"},  out_data,  0);
        checkOutput({tag, "_out_index"}, out_index, 0);
        checkOutput({tag, "_rd_addr"},   rd_addr,   0);
    endtask

    // Call this task at a falling edge. It issues start for [f, l] and then
    // follows the dump, one falling edge at a time, until busy drops. It
    // returns at the first idle falling edge, so a following call tests a
    // back-to-back restart.
    // stallMode 1: each word sees out_ready = 0, 0, 1.
    // hook 1: while word 1 is in SEND, write r3 = DEAD and r1 = BEEF.
    // hook 2: pulse start with other ranges while the dump is busy.
    // hook 3: assert reset while word 5 is in SEND.
    task automatic applyStimulus(input int f, input int l, input int stallMode,
                                 input int hook, output int words,
                                 output int doneCount, output int busyCycles);
        int  expIdx;
        int  stall;
        bit  stop;
        bit  ready;
        bit  hitReset;
        words      = 0;
        doneCount  = 0;
        busyCycles = 0;
        expIdx     = f;
        stall      = 0;
        stop       = 0;
        start      = 1'b1;
        first      = ADDR_W'(f);
        last       = ADDR_W'(l);
        out_ready  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        first = 5'd17;
        last  = 5'd1;
        for (int c = 0; c < 200 && !stop; c++) begin
            start    = 1'b0;
            hitReset = 0;
            checkOutput("err_quiet", err, 0);
            if (!busy) begin
                stop = 1;
            end else begin
                busyCycles++;
                if (done) doneCount++;
                if (!out_valid && !done)
                    checkOutput("rd_addr", rd_addr, expIdx);
                ready = 1;
                if (out_valid) begin
                    checkOutput("out_index", out_index, expIdx);
                    checkOutput("out_data", out_data, expWord[expIdx]);
                    if (stallMode == 1) ready = (stall == 2);
                    if (hook == 1 && expIdx == 1) begin
                        regs[3] = 32'h0000_DEAD;
                        regs[1] = 32'h0000_BEEF;
                    end
                    if (hook == 2 && expIdx == f + 1) begin
                        start = 1'b1;
                        first = 5'd0;
                        last  = 5'd1;
                    end
                    if (hook == 2 && expIdx == f + 2) begin
                        start = 1'b1;
                        first = 5'd20;
                        last  = 5'd3;
                    end
                    if (hook == 3 && expIdx == 5) begin
                        reset    = 1'b1;
                        ready    = 1;
                        hitReset = 1;
                    end
                    if (ready && !hitReset) begin
                        words++;
                        expIdx++;
                        stall = 0;
                    end else if (!ready) begin
                        stall++;
                    end
                end
                out_ready = ready;
                @(negedge clk);
                if (hitReset) begin
                    reset = 1'b0;
                    checkResetValues("mid_reset");
                    stop = 1;
                end
            end
        end
        checkOutput("busy_end", busy, 0);
    endtask

    initial begin
        int words;
        int doneCount;
        int busyCycles;

        reset     = 1'b1;
        start     = 1'b0;
        first     = '0;
        last      = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'(100 + i);

        repeat (2) @(negedge clk);
        checkResetValues("reset");
        reset = 1'b0;

        // Full dump 0..31 with out_ready held high.
        for (int i = 0; i < 32; i++) expWord[i] = regs[i];
        applyStimulus(0, 31, 0, 0, words, doneCount, busyCycles);
        checkOutput("full_words", words, 32);
        checkOutput("full_done", doneCount, 1);
        checkOutput("full_busy", busyCycles, 65);

        // Back-pressure 2..4, started in the first idle cycle.
        applyStimulus(2, 4, 1, 0, words, doneCount, busyCycles);
        checkOutput("bp_words", words, 3);
        checkOutput("bp_done", doneCount, 1);
        checkOutput("bp_busy", busyCycles, 13);

        // Single word.
        applyStimulus(7, 7, 0, 0, words, doneCount, busyCycles);
        checkOutput("single_words", words, 1);
        checkOutput("single_done", doneCount, 1);
        checkOutput("single_busy", busyCycles, 3);

        // Bad range: err pulses once, nothing starts.
        start = 1'b1;
        first = 5'd9;
        last  = 5'd3;
        @(negedge clk);
        start = 1'b0;
        checkOutput("bad_err", err, 1);
        checkOutput("bad_busy", busy, 0);
        checkOutput("bad_valid", out_valid, 0);
        @(negedge clk);
        checkOutput("bad_err_clear", err, 0);
        checkOutput("bad_busy2", busy, 0);
        checkOutput("bad_valid2", out_valid, 0);

        // Concurrent write during a dump of 1..3.
        expWord[1] = 32'd101;
        expWord[2] = 32'd102;
        expWord[3] = 32'h0000_DEAD;
        applyStimulus(1, 3, 0, 1, words, doneCount, busyCycles);
        checkOutput("cw_words", words, 3);
        checkOutput("cw_done", doneCount, 1);
        checkOutput("cw_busy", busyCycles, 7);
        checkOutput("cw_r1_written", regs[1], 32'h0000_BEEF);

        // Reset while word 5 is in SEND, then a clean 0..0 dump.
        for (int i = 0; i < 32; i++) expWord[i] = regs[i];
        applyStimulus(0, 31, 0, 3, words, doneCount, busyCycles);
        checkOutput("rst_words", words, 5);
        checkOutput("rst_done", doneCount, 0);
        applyStimulus(0, 0, 0, 0, words, doneCount, busyCycles);
        checkOutput("after_rst_words", words, 1);
        checkOutput("after_rst_done", doneCount, 1);
        checkOutput("after_rst_busy", busyCycles, 3);

        // Start pulses while busy are ignored.
        applyStimulus(10, 12, 0, 2, words, doneCount, busyCycles);
        checkOutput("sb_words", words, 3);
        checkOutput("sb_done", doneCount, 1);
        checkOutput("sb_busy", busyCycles, 7);
        @(negedge clk);
        checkOutput("sb_idle_after", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
